csls_sub_64_seq: RTL

Multi-cycle 64-bit subtractor, the inverse operation of the team's 64-bit carry-select adder. Computes diff = a - b - bin one CHUNK-bit slice per clock, least-significant slice first. Each slice uses a borrow-select scheme: a slice difference assuming borrow-in 0, plus a decrement converter for borrow-in 1, muxed by the registered borrow. Operands and results use a valid/ready handshake, so the block sits in an ALU pipeline.

---
 rtl/csls_sub_64_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/csls_sub_64_seq.sv
// Multi-cycle borrow-select subtractor: diff = a - b - bin, one CHUNK-bit slice per clock, LSB slice first.
// Optional macro CSLS_SUB_B2B_EN lets DONE accept the next operands in the same edge that retires a result.
module csls_sub_64_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;

  logic               in_ready_c;
  logic               accept;
  logic               last_slice;
  logic [CHUNK-1:0]   a_k, b_k;
  logic [CHUNK:0]     slice_res;

  // Returns {borrow_out, slice_diff}. The borrow-in-1 result comes from a
  // decrement of the borrow-in-0 result rather than a second subtractor.
  function automatic logic [CHUNK:0] slice_sub(input logic [CHUNK-1:0] ak,
                                               input logic [CHUNK-1:0] bk,
                                               input logic             bsel);
    logic [CHUNK:0]   s0;
    logic [CHUNK-1:0] d0;
    logic [CHUNK-1:0] d1;
    logic             c0;
    logic             c1;
    s0 = {1'b0, ak} + {1'b0, ~bk} + {{CHUNK{1'b0}}, 1'b1};
    d0 = s0[CHUNK-1:0];
    c0 = s0[CHUNK];
    d1 = d0 - CHUNK'(1);
    c1 = c0 & (d0 != '0);
    return bsel ? {~c1, d1} : {~c0, d0};
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

  assign accept     = in_valid & in_ready_c;
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_k = a_q[k*CHUNK +: CHUNK];
        b_k = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign slice_res = slice_sub(a_k, b_k, borrow_q);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        if (last_slice) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
`ifdef CSLS_SUB_B2B_EN
          state_d = in_valid ? S_CALC : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_c = (state_q == S_IDLE);
`ifdef CSLS_SUB_B2B_EN
    if ((state_q == S_DONE) && out_ready) in_ready_c = 1'b1;
`endif
  end

  // Datapath next state: operand capture, in-place slice writes, result flags.
  always_comb begin
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
        end
      end
      S_CALC: begin
        for (int k = 0; k < NSLICE; k++) begin
          if (idx_q == IDX_W'(k)) diff_d[k*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
        end
        borrow_d = slice_res[CHUNK];
        idx_d    = idx_q + IDX_W'(1);
        if (last_slice) begin
          idx_d       = '0;
          bout_d      = slice_res[CHUNK];
          ovf_d       = sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], slice_res[CHUNK-1]);
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef CSLS_SUB_B2B_EN
          if (in_valid) begin
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            idx_d    = '0;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
